arbiter_2x1: RTL and testbench

Two-requester round-robin arbiter that owns the select line of a 2:1 data multiplexer and grants the shared output path to one requester at a time. Each requester holds its grant for as long as it keeps requesting. A hold timer forces a handoff when the other side is waiting, so neither requester can starve. Sits between two producer blocks and the single shared downstream consumer in lab designs.

---
 rtl/arbiter_2x1_pkg.sv | 11 +
 rtl/arbiter_2x1_hold_counter.sv | 37 +++
 rtl/arbiter_2x1.sv | 110 +++++++++++
 tb/tb_arbiter_2x1.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/arbiter_2x1_pkg.sv
// Shared encodings for the 2:1 round-robin arbiter: FSM state codes and mux select values.
package arbiter_2x1_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GNT_A = 2'b01;
    localparam logic [1:0] ST_GNT_B = 2'b10;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/arbiter_2x1_hold_counter.sv
// Saturating hold timer: counts grant cycles and flags when the holder has used its full share.
module hold_counter #(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic at_max
);

    localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Parks at LIMIT so an uncontended holder keeps its grant without wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == LIMIT);

endmodule

// File: rtl/arbiter_2x1.sv
// Two-requester round-robin arbiter driving the select of a 2:1 data mux, with a hold timer
// that forces a handoff under contention so neither side starves.
module arbiter_2x1 #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              grant_a,
    output logic              grant_b,
    output logic              sel,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out
);

    import arbiter_2x1_pkg::*;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       last_b_q;
    logic       last_b_d;
    logic       grant_a_q;
    logic       grant_b_q;
    logic       sel_q;
    logic       hold_at_max;
    logic       hold_clear;
    logic       hold_en;

    // A tie from IDLE goes to whoever was not served last; a holder keeps the path
    // until it drops its request or its share runs out while the other side waits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    state_d = last_b_q ? ST_GNT_A : ST_GNT_B;
                end else if (req_a) begin
                    state_d = ST_GNT_A;
                end else if (req_b) begin
                    state_d = ST_GNT_B;
                end
            end
            ST_GNT_A: begin
                if (!req_a) begin
                    state_d = req_b ? ST_GNT_B : ST_IDLE;
                end else if (req_b && hold_at_max) begin
                    state_d = ST_GNT_B;
                end
            end
            ST_GNT_B: begin
                if (!req_b) begin
                    state_d = req_a ? ST_GNT_A : ST_IDLE;
                end else if (req_a && hold_at_max) begin
                    state_d = ST_GNT_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_b_d = last_b_q;
        if ((state_d == ST_GNT_A) && (state_q != ST_GNT_A)) begin
            last_b_d = 1'b0;
        end else if ((state_d == ST_GNT_B) && (state_q != ST_GNT_B)) begin
            last_b_d = 1'b1;
        end
    end

    assign hold_en    = (state_q == ST_GNT_A) || (state_q == ST_GNT_B);
    assign hold_clear = (state_d != state_q) || !hold_en;

    hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (hold_clear),
        .en     (hold_en),
        .at_max (hold_at_max)
    );

    // Grants and select are registered from the next state so they change with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_b_q  <= 1'b1;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            sel_q     <= SEL_A;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            grant_a_q <= (state_d == ST_GNT_A);
            grant_b_q <= (state_d == ST_GNT_B);
            sel_q     <= (state_d == ST_GNT_B) ? SEL_B : SEL_A;
        end
    end

    assign grant_a   = grant_a_q;
    assign grant_b   = grant_b_q;
    assign sel       = sel_q;
    assign valid_out = grant_a_q | grant_b_q;
    assign data_out  = (sel_q == SEL_B) ? data_b : data_a;

endmodule

// File: tb/tb_arbiter_2x1.sv
// Bench for arbiter_2x1: directed scenarios then random traffic, all checked against an
// owner/run-length model of the arbitration rules.
module tb_arbiter_2x1;

    localparam int DW = 8;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_a;
    logic          req_b;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic          grant_a;
    logic          grant_b;
    logic          sel;
    logic [DW-1:0] data_out;
    logic          valid_out;

    int total = 0;
    int bad   = 0;

    // Model: owner 0 = nobody, 1 = A, 2 = B; run = cycles the current owner has held so far.
    int owner = 0;
    int run   = 0;
    bit lastB = 1'b1;

    always #5 clk = ~clk;

    arbiter_2x1 #(
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .req_b     (req_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .grant_a   (grant_a),
        .grant_b   (grant_b),
        .sel       (sel),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic giveTo(input int who);
        if (who != owner) begin
            owner = who;
            run   = (who == 0) ? 0 : 1;
            if (who == 1) lastB = 1'b0;
            if (who == 2) lastB = 1'b1;
        end
    endtask

    task automatic modelStep(input bit ra, input bit rb, input bit rst);
        if (rst) begin
            owner = 0;
            run   = 0;
            lastB = 1'b1;
        end else if (owner == 0) begin
            if (ra && rb)  giveTo(lastB ? 1 : 2);
            else if (ra)   giveTo(1);
            else if (rb)   giveTo(2);
        end else begin
            bit mine  = (owner == 1) ? ra : rb;
            bit other = (owner == 1) ? rb : ra;
            int otherId = (owner == 1) ? 2 : 1;
            if (!mine)                       giveTo(other ? otherId : 0);
            else if (other && run >= MH)     giveTo(otherId);
            else                             run++;
        end
    endtask

    task automatic checkOutput();
        checkOne("grant_a",   32'(grant_a),   32'(owner == 1));
        checkOne("grant_b",   32'(grant_b),   32'(owner == 2));
        checkOne("sel",       32'(sel),       32'(owner == 2));
        checkOne("valid_out", 32'(valid_out), 32'(owner != 0));
        checkOne("data_out",  32'(data_out),  32'((owner == 2) ? data_b : data_a));
    endtask

    task automatic applyStimulus(input bit ra, input bit rb, input bit rst);
        reset = rst;
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        modelStep(ra, rb, rst);
        #1;
        checkOutput();
    endtask

    initial begin
        logic prevA;
        int   streak;

        reset  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 8'hA5;
        data_b = 8'h5A;

        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOne("reset_data_out", 32'(data_out), 32'h0000_00A5);

        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Tie straight out of reset goes to A, then a release hands over with no bubble.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOne("tie_first_a", 32'(grant_a), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOne("handoff_b", 32'(grant_b), 32'h1);
        checkOne("handoff_data", 32'(data_out), 32'h0000_005A);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Continuous contention: every completed streak must be exactly MH cycles.
        applyStimulus(1'b1, 1'b1, 1'b0);
        prevA  = grant_a;
        streak = 1;
        for (int i = 0; i < 23; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOne("contend_valid", 32'(valid_out), 32'h1);
            if (grant_a !== prevA) begin
                checkOne("hold_len", 32'(streak), 32'(MH));
                streak = 1;
                prevA  = grant_a;
            end else begin
                streak++;
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOne("release_idle", 32'(valid_out), 32'h0);

        // Fairness through IDLE in both directions.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOne("fair_b", 32'(grant_b), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOne("fair_a", 32'(grant_a), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset in the middle of a B grant with contention pending.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOne("midreset_data", 32'(data_out), 32'h0000_00A5);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            data_a = 8'($urandom);
            data_b = 8'($urandom);
            applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
